// File: rtl/fetch_pipe_unit_pkg.sv
// fetch_pipe_unit_pkg: shared pipeline constants, next-PC select codes and fetch FSM states
package fetch_pipe_unit_pkg;
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;
  typedef enum logic [1:0] {
    SEL_SEQUENTIAL = 2'b00,
    SEL_BRANCH     = 2'b01,
    SEL_JAL        = 2'b10,
    SEL_JALR       = 2'b11
  } next_pc_select_t;
  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_DROP = 2'b10,
    ST_HOLD = 2'b11
  } fetch_state_t;
endpackage

// File: rtl/fetch_pipe_unit.sv
// fetch_pipe_unit: instruction fetch stage, one outstanding request, stall hold buffer, execute redirect
module fetch_pipe_unit
  import fetch_pipe_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_BITS = 20,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic [1:0]              next_PC_select_execute,
  input  logic                    branch_taken_execute,
  input  logic [ADDRESS_BITS-1:0] branch_target_execute,
  input  logic [ADDRESS_BITS-1:0] JAL_target_execute,
  input  logic [ADDRESS_BITS-1:0] JALR_target_execute,
  output logic                    imem_req,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  input  logic                    imem_ready,
  input  logic                    imem_valid,
  input  logic [DATA_WIDTH-1:0]   imem_rdata,
  output logic [DATA_WIDTH-1:0]   instruction_decode,
  output logic [ADDRESS_BITS-1:0] PC_decode,
  output logic                    valid_decode
);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTRUCTION);
  fetch_state_t state;
  next_pc_select_t select;
  logic redirect;
  logic [ADDRESS_BITS-1:0] pc, pc_plus_4, redirect_target, hold_pc;
  logic [DATA_WIDTH-1:0] hold_instruction;
  // resolve the execute-stage redirect and whether a fetch may issue this cycle
  always_comb begin
    select = next_pc_select_t'(next_PC_select_execute);
    redirect = select == SEL_JAL || select == SEL_JALR || (select == SEL_BRANCH && branch_taken_execute);
    redirect_target = select == SEL_JAL ? JAL_target_execute :
                      select == SEL_JALR ? JALR_target_execute & ~ADDRESS_BITS'(1) : branch_target_execute;
    pc_plus_4 = pc + ADDRESS_BITS'(4);
    imem_req = !reset && state == ST_RUN && !stall && !redirect;
    imem_addr = pc;
  end
  // fetch FSM: redirect beats stall; responses go to decode, or to the hold buffer while stalled
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= ST_RUN;
      pc <= RESET_PC;
      instruction_decode <= NOP;
      PC_decode <= '0;
      valid_decode <= 1'b0;
      hold_instruction <= '0;
      hold_pc <= '0;
    end else if (redirect) begin
      pc <= redirect_target;
      hold_instruction <= '0;
      hold_pc <= '0;
      if (state == ST_DROP) begin
        state <= imem_valid ? ST_RUN : ST_DROP;
      end else begin
        state <= (state == ST_WAIT && !imem_valid) ? ST_DROP : ST_RUN;
        instruction_decode <= NOP;
        PC_decode <= '0;
        valid_decode <= 1'b0;
      end
    end else begin
      case (state)
        ST_RUN: if (imem_req && imem_ready) state <= ST_WAIT;
        ST_WAIT:
          if (imem_valid) begin
            pc <= pc_plus_4;
            if (stall) begin
              hold_instruction <= imem_rdata;
              hold_pc <= pc;
              state <= ST_HOLD;
            end else begin
              instruction_decode <= imem_rdata;
              PC_decode <= pc;
              valid_decode <= 1'b1;
              state <= ST_RUN;
            end
          end
        ST_DROP: if (imem_valid) state <= ST_RUN;
        ST_HOLD:
          if (!stall) begin
            instruction_decode <= hold_instruction;
            PC_decode <= hold_pc;
            valid_decode <= 1'b1;
            state <= ST_RUN;
          end
      endcase
    end
endmodule
